// File: rtl/fadd_d_arbiter_pkg.sv
// Shared types and constants for the double-precision add-unit arbiter.
package fadd_d_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_LE   = 3'd4;
    localparam logic [2:0] OP_MAX  = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef struct packed {
        logic [1:0]  state;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        illegal_op;
        logic        overflow;
        logic        err;
    } regs_t;

    localparam regs_t REGS_RST = '{
        state:      ST_IDLE,
        op:         OP_ADD,
        a:          64'd0,
        b:          64'd0,
        res:        64'd0,
        illegal_op: 1'b0,
        overflow:   1'b0,
        err:        1'b0
    };

    // Bit order matches {min,max,le,lt,eq,sub,add}; the reserved code maps to no flag.
    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        logic [6:0] oh;
        oh = '0;
        if (op != OP_RSVD) oh[op] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fadd_d_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr, wrapping.
// Zero latency; no state.
module fadd_d_arbiter_rr_pick #(
    parameter int REQ_NUM = 2,
    parameter int IDW     = 1
) (
    input  logic [REQ_NUM-1:0] vld_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [REQ_NUM-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            j = int'(ptr_i) + i;
            if (j >= REQ_NUM) j = j - REQ_NUM;
            if (!found && vld_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fadd_d_arbiter.sv
// Round-robin arbiter sharing one double-precision add/compare unit; one op in flight,
// tagged response held until accepted, watchdog turns a silent unit into an error response.
module fadd_d_arbiter
    import fadd_d_arbiter_pkg::*;
#(
    parameter  int REQ_NUM = 2,
    parameter  int TAG_W   = 4,
    parameter  int TIMEOUT = 15,
    localparam int IDW     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic [REQ_NUM-1:0]       i_req_valid,
    output logic [REQ_NUM-1:0]       o_req_ready,
    input  logic [3*REQ_NUM-1:0]     i_req_op,
    input  logic [64*REQ_NUM-1:0]    i_req_a,
    input  logic [64*REQ_NUM-1:0]    i_req_b,
    input  logic [TAG_W*REQ_NUM-1:0] i_req_tag,
    output logic                     o_fa_ena,
    output logic                     o_fa_add,
    output logic                     o_fa_sub,
    output logic                     o_fa_eq,
    output logic                     o_fa_lt,
    output logic                     o_fa_le,
    output logic                     o_fa_max,
    output logic                     o_fa_min,
    output logic [63:0]              o_fa_a,
    output logic [63:0]              o_fa_b,
    input  logic [63:0]              i_fa_res,
    input  logic                     i_fa_illegal_op,
    input  logic                     i_fa_overflow,
    input  logic                     i_fa_valid,
    input  logic                     i_fa_busy,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic [IDW-1:0]           o_resp_id,
    output logic [TAG_W-1:0]         o_resp_tag,
    output logic [63:0]              o_resp_res,
    output logic                     o_resp_illegal_op,
    output logic                     o_resp_overflow,
    output logic                     o_resp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    regs_t            r_q, r_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [REQ_NUM-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               grant;
    logic [2:0]         win_op;
    logic [6:0]         fa_flags;

    fadd_d_arbiter_rr_pick #(
        .REQ_NUM (REQ_NUM),
        .IDW     (IDW)
    ) u_rr_pick (
        .vld_i (i_req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Reset is folded in so the combinational accept is also quiet while reset is held.
    assign grant       = i_nrst && (r_q.state == ST_IDLE) && (|i_req_valid) && !i_fa_busy;
    assign o_req_ready = grant ? pick_gnt : '0;
    assign win_op      = i_req_op[int'(pick_idx)*3 +: 3];

    always_comb begin
        r_d   = r_q;
        tag_d = tag_q;
        id_d  = id_q;
        rr_d  = rr_q;
        cnt_d = cnt_q;
        case (r_q.state)
            ST_IDLE: begin
                if (grant) begin
                    r_d.op = win_op;
                    r_d.a  = i_req_a[int'(pick_idx)*64 +: 64];
                    r_d.b  = i_req_b[int'(pick_idx)*64 +: 64];
                    tag_d  = i_req_tag[int'(pick_idx)*TAG_W +: TAG_W];
                    id_d   = pick_idx;
                    if (win_op == OP_RSVD) begin
                        r_d.res        = '0;
                        r_d.illegal_op = 1'b1;
                        r_d.overflow   = 1'b0;
                        r_d.err        = 1'b0;
                        r_d.state      = ST_RESP;
                    end else begin
                        r_d.state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d     = '0;
                r_d.state = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the timeout cycle still counts as a good completion.
                if (i_fa_valid) begin
                    r_d.res        = i_fa_res;
                    r_d.illegal_op = i_fa_illegal_op;
                    r_d.overflow   = i_fa_overflow;
                    r_d.err        = 1'b0;
                    r_d.state      = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    r_d.res        = '0;
                    r_d.illegal_op = 1'b0;
                    r_d.overflow   = 1'b0;
                    r_d.err        = 1'b1;
                    r_d.state      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    rr_d      = (id_q == IDW'(REQ_NUM - 1)) ? '0 : id_q + 1'b1;
                    r_d.state = ST_IDLE;
                end
            end
            default: r_d.state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q   <= REGS_RST;
            tag_q <= '0;
            id_q  <= '0;
            rr_q  <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            tag_q <= tag_d;
            id_q  <= id_d;
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_fa_ena = (r_q.state == ST_ISSUE);
    assign fa_flags = o_fa_ena ? op_onehot(r_q.op) : 7'd0;
    assign {o_fa_min, o_fa_max, o_fa_le, o_fa_lt, o_fa_eq, o_fa_sub, o_fa_add} = fa_flags;
    assign o_fa_a   = r_q.a;
    assign o_fa_b   = r_q.b;

    assign o_resp_valid      = (r_q.state == ST_RESP);
    assign o_resp_id         = id_q;
    assign o_resp_tag        = tag_q;
    assign o_resp_res        = r_q.res;
    assign o_resp_illegal_op = r_q.illegal_op;
    assign o_resp_overflow   = r_q.overflow;
    assign o_resp_err        = r_q.err;

endmodule

// File: tb/tb_fadd_d_arbiter.sv
// Randomized bench for fadd_d_arbiter: a stub add unit plus a transaction-level model
// predicting grant order, unit pin activity and response contents.
module tb_fadd_d_arbiter;

    localparam int N    = 2;
    localparam int TW   = 4;
    localparam int TOUT = 15;

    logic           i_clk = 1'b0;
    logic           i_nrst;
    logic [N-1:0]   i_req_valid;
    logic [N-1:0]   o_req_ready;
    logic [3*N-1:0] i_req_op;
    logic [64*N-1:0] i_req_a, i_req_b;
    logic [TW*N-1:0] i_req_tag;
    logic o_fa_ena, o_fa_add, o_fa_sub, o_fa_eq, o_fa_lt, o_fa_le, o_fa_max, o_fa_min;
    logic [63:0]    o_fa_a, o_fa_b, i_fa_res;
    logic           i_fa_illegal_op, i_fa_overflow, i_fa_valid, i_fa_busy;
    logic           o_resp_valid, i_resp_ready;
    logic [0:0]     o_resp_id;
    logic [TW-1:0]  o_resp_tag;
    logic [63:0]    o_resp_res;
    logic           o_resp_illegal_op, o_resp_overflow, o_resp_err;

    fadd_d_arbiter #(.REQ_NUM(N), .TAG_W(TW), .TIMEOUT(TOUT)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_tag(i_req_tag),
        .o_fa_ena(o_fa_ena), .o_fa_add(o_fa_add), .o_fa_sub(o_fa_sub), .o_fa_eq(o_fa_eq),
        .o_fa_lt(o_fa_lt), .o_fa_le(o_fa_le), .o_fa_max(o_fa_max), .o_fa_min(o_fa_min),
        .o_fa_a(o_fa_a), .o_fa_b(o_fa_b), .i_fa_res(i_fa_res),
        .i_fa_illegal_op(i_fa_illegal_op), .i_fa_overflow(i_fa_overflow),
        .i_fa_valid(i_fa_valid), .i_fa_busy(i_fa_busy),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_id(o_resp_id),
        .o_resp_tag(o_resp_tag), .o_resp_res(o_resp_res),
        .o_resp_illegal_op(o_resp_illegal_op), .o_resp_overflow(o_resp_overflow),
        .o_resp_err(o_resp_err)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int rr    = 0;
    int gcnt[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] vm);
        for (int k = 0; k < N; k++)
            if (vm[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    function automatic logic [6:0] fa_flag_vec();
        return {o_fa_min, o_fa_max, o_fa_le, o_fa_lt, o_fa_eq, o_fa_sub, o_fa_add};
    endfunction

    // mode 0: unit answers 8 cycles after start; mode 1: unit never answers.
    task automatic run_txn(input logic [N-1:0] vm, input int mode, input int hold,
                           input bit busy_first, input bit force7, input bit directed);
        int w, waited;
        logic [2:0]    op[N];
        logic [63:0]   a[N], b[N];
        logic [TW-1:0] tg[N];
        logic [63:0]   r, exp_res;
        logic          il, ov, exp_il, exp_ov, exp_err;
        for (int i = 0; i < N; i++) begin
            op[i] = 3'($urandom_range(0, 6));
            a[i]  = {$urandom, $urandom};
            b[i]  = {$urandom, $urandom};
            tg[i] = TW'($urandom);
        end
        r  = {$urandom, $urandom};
        il = 1'($urandom);
        ov = 1'($urandom);
        w  = model_pick(vm);
        if (force7) op[w] = 3'd7;
        if (directed) begin
            op[w] = 3'd0; a[w] = 64'h3FF0000000000000; b[w] = 64'h4000000000000000;
            tg[w] = 4'd5; r = 64'h4008000000000000; il = 1'b0; ov = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            i_req_op[i*3 +: 3]   = op[i];
            i_req_a[i*64 +: 64]  = a[i];
            i_req_b[i*64 +: 64]  = b[i];
            i_req_tag[i*TW +: TW] = tg[i];
        end
        if (busy_first) begin
            @(negedge i_clk); i_fa_busy = 1'b1; i_req_valid = vm; #1;
            chk("busy_blocks_grant", 64'(o_req_ready), 64'd0);
        end
        @(negedge i_clk); i_fa_busy = 1'b0; i_req_valid = vm; #1;
        chk("grant", 64'(o_req_ready), 64'(1 << w));
        if (o_req_ready == N'(1 << w)) gcnt[w]++;
        @(negedge i_clk); #1;
        chk("req_ready_after_grant", 64'(o_req_ready), 64'd0);
        if (op[w] == 3'd7) begin
            chk("rsvd_no_ena", 64'(o_fa_ena), 64'd0);
            chk("rsvd_resp_valid", 64'(o_resp_valid), 64'd1);
            exp_res = '0; exp_il = 1'b1; exp_ov = 1'b0; exp_err = 1'b0;
        end else begin
            chk("ena", 64'(o_fa_ena), 64'd1);
            chk("op_flags", 64'(fa_flag_vec()), 64'(7'd1 << op[w]));
            chk("fa_a", o_fa_a, a[w]);
            chk("fa_b", o_fa_b, b[w]);
            if (mode == 0) begin
                repeat (7) begin
                    @(negedge i_clk); #1;
                    chk("wait_no_ena", 64'({o_fa_ena, fa_flag_vec()}), 64'd0);
                    chk("wait_no_resp", 64'({o_resp_valid, o_req_ready}), 64'd0);
                end
                @(negedge i_clk);
                i_fa_valid = 1'b1; i_fa_res = r; i_fa_illegal_op = il; i_fa_overflow = ov; #1;
                chk("no_resp_before_valid", 64'(o_resp_valid), 64'd0);
                @(negedge i_clk); i_fa_valid = 1'b0; #1;
                chk("resp_latency", 64'(o_resp_valid), 64'd1);
                exp_res = r; exp_il = il; exp_ov = ov; exp_err = 1'b0;
            end else begin
                waited = 0;
                while (!o_resp_valid && waited < 40) begin
                    @(negedge i_clk); #1; waited++;
                end
                chk("timeout_resp_seen", 64'(o_resp_valid), 64'd1);
                exp_res = '0; exp_il = 1'b0; exp_ov = 1'b0; exp_err = 1'b1;
            end
        end
        chk("resp_id", 64'(o_resp_id), 64'(w));
        chk("resp_tag", 64'(o_resp_tag), 64'(tg[w]));
        chk("resp_res", o_resp_res, exp_res);
        chk("resp_err", 64'(o_resp_err), 64'(exp_err));
        if (mode == 0 || op[w] == 3'd7) begin
            chk("resp_illegal", 64'(o_resp_illegal_op), 64'(exp_il));
            chk("resp_overflow", 64'(o_resp_overflow), 64'(exp_ov));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            i_fa_valid = (h == 0); i_fa_res = ~exp_res; #1;
            chk("hold_valid", 64'(o_resp_valid), 64'd1);
            chk("hold_res", o_resp_res, exp_res);
            chk("hold_tag", 64'(o_resp_tag), 64'(tg[w]));
            chk("hold_no_grant", 64'(o_req_ready), 64'd0);
        end
        @(negedge i_clk); i_fa_valid = 1'b0; i_resp_ready = 1'b1; #1;
        chk("hs_res", o_resp_res, exp_res);
        @(posedge i_clk);
        rr = (w + 1) % N;
        @(negedge i_clk); i_resp_ready = 1'b0; i_req_valid = '0; #1;
        chk("resp_dropped", 64'(o_resp_valid), 64'd0);
    endtask

    initial begin
        i_nrst = 1'b0; i_req_valid = '0; i_req_op = '0; i_req_a = '0; i_req_b = '0;
        i_req_tag = '0; i_fa_res = '0; i_fa_illegal_op = 1'b0; i_fa_overflow = 1'b0;
        i_fa_valid = 1'b0; i_fa_busy = 1'b0; i_resp_ready = 1'b0;
        gcnt[0] = 0; gcnt[1] = 0;
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_fa", 64'({o_fa_ena, fa_flag_vec()}), 64'd0);
        chk("rst_fa_a", o_fa_a, 64'd0);
        chk("rst_resp_fields", 64'({o_resp_id, o_resp_tag, o_resp_err, o_resp_illegal_op}), 64'd0);
        @(negedge i_clk); i_nrst = 1'b1;

        run_txn(2'b01, 0, 0, 1'b0, 1'b0, 1'b1);   // directed add, tag 5
        for (int i = 0; i < 20; i++) run_txn(2'b11, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("fair0", 64'(gcnt[0]), 64'd11);       // the directed op above was also id0
        chk("fair1", 64'(gcnt[1]), 64'd10);
        run_txn(2'b10, 0, 0, 1'b0, 1'b1, 1'b0);   // reserved op
        run_txn(2'b11, 0, 6, 1'b0, 1'b0, 1'b0);   // long backpressure
        run_txn(2'b01, 1, 0, 1'b0, 1'b0, 1'b0);   // stuck unit
        run_txn(2'b10, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++)
            run_txn(N'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                    $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 5) == 0), 1'b0);

        // Reset while the unit is working: everything clears, the late result is dropped.
        i_req_op = '0; i_req_tag = '1;
        @(negedge i_clk); i_req_valid = 2'b01; #1;
        chk("mid_grant", 64'(o_req_ready), 64'd1);
        @(negedge i_clk); #1;
        chk("mid_ena", 64'(o_fa_ena), 64'd1);
        repeat (3) @(negedge i_clk);
        @(negedge i_clk); i_nrst = 1'b0; #1;
        chk("arst_outputs", 64'({o_resp_valid, o_fa_ena, o_req_ready, o_resp_tag}), 64'd0);
        chk("arst_fa_a", o_fa_a, 64'd0);
        @(negedge i_clk); i_req_valid = '0; i_nrst = 1'b1; rr = 0;
        repeat (3) @(negedge i_clk);
        @(negedge i_clk); i_fa_valid = 1'b1;
        @(negedge i_clk); i_fa_valid = 1'b0;
        repeat (4) begin
            @(negedge i_clk); #1;
            chk("late_valid_ignored", 64'(o_resp_valid), 64'd0);
        end
        run_txn(2'b11, 0, 1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
